// File: rtl/divider_restoring_asmd_pkg.sv
// Shared definitions for the restoring divider: state encoding, default word
// width and counter sizing.
package divider_restoring_asmd_pkg;

  localparam int L_WORD_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_idle  = 2'd0,
    S_shift = 2'd1,
    S_sub   = 2'd2
  } state_t;

  // Iteration counter must hold 0 .. L_word-1 with one spare bit.
  function automatic int cnt_width(input int l_word);
    return $clog2(l_word) + 1;
  endfunction

endpackage

// File: rtl/divider_datapath_unit.sv
// Restoring-division datapath: partial remainder R, quotient/low-dividend Q,
// divisor D and iteration counter, stepped by Load/Shift/Sub strobes.
module divider_datapath_unit
  import divider_restoring_asmd_pkg::*;
#(
  parameter int L_word = L_WORD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Load,
  input  logic                  Shift,
  input  logic                  Sub,
  input  logic [2*L_word-1:0]   dividend,
  input  logic [L_word-1:0]     divisor,
  output logic                  last,
  output logic [L_word-1:0]     q_fin,
  output logic [L_word-1:0]     r_fin
);

  localparam int CW = cnt_width(L_word);

  // R is one bit wider than D so the left shift never loses the top bit.
  logic [L_word:0]   r;
  logic [L_word-1:0] q;
  logic [L_word-1:0] d;
  logic [CW-1:0]     cnt;

  logic              ge;
  logic [L_word:0]   r_after;

  assign ge      = r >= {1'b0, d};
  assign r_after = ge ? r - {1'b0, d} : r;
  assign q_fin   = {q[L_word-1:1], ge};
  assign r_fin   = r_after[L_word-1:0];
  assign last    = cnt == CW'(L_word - 1);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, as the hardware does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r   <= '0;
      q   <= '0;
      d   <= '0;
      cnt <= '0;
    end else if (Load) begin
      r   <= {1'b0, dividend[2*L_word-1:L_word]};
      q   <= dividend[L_word-1:0];
      d   <= divisor;
      cnt <= '0;
    end else if (Shift) begin
      {r, q} <= {r[L_word-1:0], q, 1'b0};
    end else if (Sub) begin
      r   <= r_after;
      q   <= q_fin;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/divider_restoring_asmd.sv
// Sequential restoring divider (ASMD style): 2*L_word by L_word unsigned,
// rejects divide-by-zero and quotient overflow in a single idle cycle.
module divider_restoring_asmd
  import divider_restoring_asmd_pkg::*;
#(
  parameter int L_word = L_WORD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [2*L_word-1:0]   dividend,
  input  logic [L_word-1:0]     divisor,
  output logic [L_word-1:0]     quotient,
  output logic [L_word-1:0]     remainder,
  output logic                  Ready,
  output logic                  Div_zero,
  output logic                  Overflow
);

  state_t            state, state_next;
  logic              load, shift, sub, last;
  logic              div_is_zero, quot_ovf;
  logic [L_word-1:0] q_fin, r_fin;

  // Quotient fits in L_word bits only if the upper dividend half is below D.
  assign div_is_zero = divisor == '0;
  assign quot_ovf    = dividend[2*L_word-1:L_word] >= divisor;
  assign Ready       = state == S_idle;

  divider_datapath_unit #(.L_word(L_word)) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .Load     (load),
    .Shift    (shift),
    .Sub      (sub),
    .dividend (dividend),
    .divisor  (divisor),
    .last     (last),
    .q_fin    (q_fin),
    .r_fin    (r_fin)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_idle;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    sub        = 1'b0;
    case (state)
      S_idle: begin
        if (Start && !div_is_zero && !quot_ovf) begin
          load       = 1'b1;
          state_next = S_shift;
        end
      end
      S_shift: begin
        shift      = 1'b1;
        state_next = S_sub;
      end
      S_sub: begin
        sub        = 1'b1;
        state_next = last ? S_idle : S_shift;
      end
      default: state_next = S_idle;
    endcase
  end

  // Visible results change only on a rejected request or on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      Div_zero  <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      case (state)
        S_idle: begin
          if (Start) begin
            if (div_is_zero) begin
              Div_zero  <= 1'b1;
              Overflow  <= 1'b0;
              quotient  <= '0;
              remainder <= '0;
            end else if (quot_ovf) begin
              Div_zero  <= 1'b0;
              Overflow  <= 1'b1;
              quotient  <= '0;
              remainder <= '0;
            end else begin
              Div_zero <= 1'b0;
              Overflow <= 1'b0;
            end
          end
        end
        S_sub: begin
          if (last) begin
            quotient  <= q_fin;
            remainder <= r_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_restoring_asmd.sv
// Self-checking bench for divider_restoring_asmd (L_word=4): arithmetic
// reference model, directed cases, exhaustive sweep and random traffic.
module tb_divider_restoring_asmd;

  localparam int L    = 4;
  localparam int LAT  = 2 * L;
  localparam int QMAX = (1 << L) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           Start;
  logic [2*L-1:0] dividend;
  logic [L-1:0]   divisor;
  logic [L-1:0]   quotient, remainder;
  logic           Ready, Div_zero, Overflow;

  int n_checks = 0;
  int n_fail   = 0;

  divider_restoring_asmd #(.L_word(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .Ready     (Ready),
    .Div_zero  (Div_zero),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference model: a request either resolves at once (error) or produces
  // dividend/divisor and dividend%divisor after a fixed latency.
  int           busy;
  logic [L-1:0] exp_q, exp_r, pend_q, pend_r;
  logic         exp_dz, exp_ov;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= 0;
      exp_q  <= '0;
      exp_r  <= '0;
      exp_dz <= 1'b0;
      exp_ov <= 1'b0;
    end else if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) begin
        exp_q <= pend_q;
        exp_r <= pend_r;
      end
    end else if (Start) begin
      if (divisor == 0) begin
        exp_dz <= 1'b1; exp_ov <= 1'b0; exp_q <= '0; exp_r <= '0;
      end else if (int'(dividend) / int'(divisor) > QMAX) begin
        exp_dz <= 1'b0; exp_ov <= 1'b1; exp_q <= '0; exp_r <= '0;
      end else begin
        exp_dz <= 1'b0;
        exp_ov <= 1'b0;
        pend_q <= L'(int'(dividend) / int'(divisor));
        pend_r <= L'(int'(dividend) % int'(divisor));
        busy   <= LAT;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("ready", int'(Ready), int'(busy == 0));
      if (busy == 0) begin
        check("quotient", int'(quotient), int'(exp_q));
        check("remainder", int'(remainder), int'(exp_r));
        check("div_zero", int'(Div_zero), int'(exp_dz));
        check("overflow", int'(Overflow), int'(exp_ov));
      end
    end
  end

  // Inputs change 2 time units after a rising edge.
  task automatic wait_ready(output int busy_cycles);
    busy_cycles = 0;
    @(negedge clk);
    while (!Ready && busy_cycles < 40) begin
      busy_cycles++;
      @(negedge clk);
    end
    if (!Ready) check("ready_timeout", 0, 1);
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2*L-1:0] dd, input logic [L-1:0] dv);
    Start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #2;
    Start = 1'b0;
  endtask

  task automatic run_req(input logic [2*L-1:0] dd, input logic [L-1:0] dv,
                         output int busy_cycles);
    issue(dd, dv);
    wait_ready(busy_cycles);
  endtask

  task automatic pin(input string name, input int eq, input int er,
                     input int edz, input int eov);
    check({name, "_q"}, int'(quotient), eq);
    check({name, "_r"}, int'(remainder), er);
    check({name, "_dz"}, int'(Div_zero), edz);
    check({name, "_ov"}, int'(Overflow), eov);
  endtask

  initial begin
    int bc;
    reset    = 1'b1;
    Start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check("reset_ready", int'(Ready), 1);
    pin("reset", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #2;

    // 100 / 7 = 14 r 2, busy for exactly 8 cycles
    run_req(8'd100, 4'd7, bc);
    check("latency_100_7", bc, 8);
    pin("n100_7", 14, 2, 0, 0);

    // 112 / 7 = 16 does not fit in 4 bits
    run_req(8'd112, 4'd7, bc);
    check("latency_ovf", bc, 0);
    pin("ovf112_7", 0, 0, 0, 1);

    // divide by zero, then a valid request clears the flag
    run_req(8'd55, 4'd0, bc);
    check("latency_dz", bc, 0);
    pin("dz55_0", 0, 0, 1, 0);
    run_req(8'd55, 4'd5, bc);
    pin("n55_5", 11, 0, 0, 0);

    // Start with new operands while busy must be ignored
    issue(8'd100, 4'd7);
    repeat (3) @(posedge clk);
    #2;
    Start = 1'b1; dividend = 8'd200; divisor = 4'd3;
    @(posedge clk);
    #2;
    Start = 1'b0; dividend = 8'd9; divisor = 4'd1;
    wait_ready(bc);
    pin("busy_start", 14, 2, 0, 0);

    // reset after 3 cycles of 200/13 aborts, then a fresh 200/13 = 15 r 5
    issue(8'd200, 4'd13);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_ready", int'(Ready), 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", int'(Ready), 1);
    pin("post_reset", 0, 0, 0, 0);
    @(posedge clk);
    #2;
    run_req(8'd200, 4'd13, bc);
    pin("n200_13", 15, 5, 0, 0);

    // exhaustive sweep of every non-zero divisor
    for (int dd = 0; dd < 256; dd++) begin
      for (int dv = 1; dv < 16; dv++) begin
        run_req(8'(dd), 4'(dv), bc);
        if (dd / dv > QMAX) begin
          check("sweep_ovf", int'(Overflow), 1);
        end else begin
          check("sweep_identity", int'(quotient) * dv + int'(remainder), dd);
          check("sweep_rem_lt_div", int'(int'(remainder) < dv), 1);
        end
      end
    end

    // random traffic, including Start while busy and occasional resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      Start    = ($urandom_range(0, 2) == 0);
      dividend = 8'($urandom);
      divisor  = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      reset    = ($urandom_range(0, 499) == 0);
      @(posedge clk);
      #2;
    end
    Start = 1'b0;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_restoring_asmd.md
DIVIDER_RESTORING_ASMD -- requirements
Module: divider_restoring_asmd

Interface
REQ-001 Parameter L_word, default 4, divisor/quotient/remainder width; dividend width 2*L_word.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request; sampled only in S_idle.
REQ-005 dividend  input  2*L_word  unsigned dividend; sampled on the accepted Start edge.
REQ-006 divisor  input  L_word  unsigned divisor; sampled on the accepted Start edge.
REQ-007 quotient  output  L_word  registered quotient.
REQ-008 remainder  output  L_word  registered remainder.
REQ-009 Ready  output  1  high iff state == S_idle (combinational decode of state).
REQ-010 Div_zero  output  1  registered flag; last request had divisor == 0.
REQ-011 Overflow  output  1  registered flag; last request had a quotient wider than L_word bits.

Function
REQ-012 The block SHALL have states S_idle, S_shift and S_sub, with no other reachable state; unused encodings SHALL go to S_idle.
REQ-013 In S_idle with Start=0, the block SHALL stay idle and hold all outputs.
REQ-014 In S_idle with Start=1 and divisor==0, the block SHALL set Div_zero=1, clear Overflow, clear quotient and remainder to 0, and stay in S_idle.
REQ-015 In S_idle with Start=1, divisor!=0 and dividend[2L-1:L] >= divisor, the block SHALL set Overflow=1, clear Div_zero, clear quotient and remainder to 0, and stay in S_idle.
REQ-016 Otherwise, Start=1 SHALL be accepted, with these actions on that edge:
- load R (L_word+1 bits) with dividend[2L-1:L];
- load Q with dividend[L-1:0];
- load D with divisor;
- clear the iteration counter;
- clear both flags;
- go to S_shift.
REQ-017 In S_shift, the block SHALL perform {R,Q} <= {R,Q} << 1, with R[0] taking Q[L-1] and Q[0] taking 0, and then go to S_sub.
REQ-018 In S_sub, the block SHALL:
- if R >= D, set R <= R - D and Q[0] <= 1;
- otherwise leave R unchanged and Q[0] <= 0;
- increment the counter.
REQ-019 From S_sub, the block SHALL return to S_idle when the counter reaches L_word-1 before incrementing, and go to S_shift otherwise.
REQ-020 On the S_sub to S_idle edge, the block SHALL write quotient <= final Q and remainder <= final R[L_word-1:0].
REQ-021 Latency SHALL be exactly 2*L_word cycles from the accepted Start edge to Ready=1; results SHALL be valid whenever Ready=1.
REQ-022 quotient and remainder SHALL hold their previous values during S_shift/S_sub, changing only per REQ-014, REQ-015 and REQ-020.
REQ-023 Start asserted outside S_idle SHALL be ignored; dividend and divisor changes during operation SHALL have no effect.
REQ-024 A rejected Start (REQ-014/015) SHALL still leave Ready=1 on the following cycle, allowing back-to-back requests.
REQ-025 R SHALL be L_word+1 bits so the shifted partial remainder never truncates; R < 2*D SHALL hold after every S_sub.
REQ-026 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every non-error request.

Reset
REQ-027 On reset, the block SHALL asynchronously set: state=S_idle; quotient, remainder, R, Q, D and counter = 0; Div_zero and Overflow = 0.
REQ-028 Reset asserted mid-operation SHALL abort the division with no partial result visible, leaving Ready=1 after release.

Structure
REQ-029 A shared package SHALL hold the state encoding constants and the L_word default; counter width SHALL be $clog2(L_word)+1.
REQ-030 The datapath (R, Q, D, counter, comparator/subtractor) SHALL be one sub-module, divider_datapath_unit, controlled by Load, Shift and Sub strobes from a top-level controller.

Verification (L_word=4)
REQ-031 Normal case: dividend=100, divisor=7, Start pulse -> Ready low for 8 cycles, then quotient=14, remainder=2, flags 0.
REQ-032 Overflow: dividend=112, divisor=7 -> Overflow=1 next cycle, quotient=0, remainder=0, Ready stays 1.
REQ-033 Divide by zero: dividend=55, divisor=0 -> Div_zero=1, Overflow=0, outputs 0; a following valid request (e.g. 55/5) clears Div_zero and yields quotient=11, remainder=0.
REQ-034 Busy start: Start re-asserted with new operands during operation of 100/7 -> ignored; result 14 r 2.
REQ-035 Reset during operation: reset after 3 cycles of 200/13 -> Ready=1, outputs 0; a new 200/13 request yields quotient=15, remainder=5.
REQ-036 Exhaustive: all 2^8 x 15 non-zero-divisor pairs checked against REQ-026 and the overflow rule.
